// File: rtl/dac_serial_tx.sv
// Two-frame SPI transmitter for a dual-channel 12-bit DAC (channel A, then B).
// Define DST_LDAC_EN to add a trailing LDAC pulse; otherwise ldac_n is tied low after reset.
module dac_serial_tx #(
  parameter int   CLK_DIV  = 4,
  parameter logic CFG_BUF  = 1'b0,
  parameter logic CFG_GA_N = 1'b1
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        dst_en_i,
  input  logic        dst_start_i,
  input  logic [11:0] dst_ch_a_i,
  input  logic [11:0] dst_ch_b_i,
  input  logic        dst_ovr_clr_i,
  output logic        dst_cs_n_o,
  output logic        dst_sck_o,
  output logic        dst_mosi_o,
  output logic        dst_ldac_n_o,
  output logic        dst_busy_o,
  output logic        dst_done_o,
  output logic        dst_ovr_o
);

  localparam int             DW      = $clog2(2 * CLK_DIV + 1);
  localparam logic [DW-1:0]  HALF_M1 = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0]  FULL_M1 = DW'(2 * CLK_DIV - 1);

`ifdef DST_LDAC_EN
  typedef enum logic [2:0] {S_IDLE, S_CS_SETUP, S_SHIFT, S_CS_HOLD, S_GAP, S_LDAC} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_CS_SETUP, S_SHIFT, S_CS_HOLD, S_GAP} state_t;
`endif

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    bit_q, bit_d;
  logic          ch_q, ch_d;
  logic [11:0]   samp_a_q, samp_a_d;
  logic [11:0]   samp_b_q, samp_b_d;
  logic          cs_n_q, cs_n_d;
  logic          sck_q, sck_d;
  logic          mosi_q, mosi_d;
  logic          ldac_n_q, ldac_n_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ovr_q, ovr_d;
  logic          accept;
  logic [15:0]   word_d;

  // Sequencing. Frame B's trailing gap is replaced by the LDAC pulse (or by
  // IDLE), which gives the 72/70 * CLK_DIV busy length.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q + 1'b1;
    bit_d    = bit_q;
    ch_d     = ch_q;
    samp_a_d = samp_a_q;
    samp_b_d = samp_b_q;
    ovr_d    = ovr_q;
    accept   = dst_start_i && dst_en_i && !busy_q;

    if (dst_ovr_clr_i) ovr_d = 1'b0;
    if (dst_start_i && busy_q) ovr_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        div_d = '0;
        if (accept) begin
          state_d  = S_CS_SETUP;
          ch_d     = 1'b0;
          bit_d    = '0;
          samp_a_d = dst_ch_a_i;
          samp_b_d = dst_ch_b_i;
        end
      end
      S_CS_SETUP: begin
        if (div_q == HALF_M1) begin
          state_d = S_SHIFT;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      S_SHIFT: begin
        if (div_q == FULL_M1) begin
          div_d = '0;
          if (bit_q == 4'd15) state_d = S_CS_HOLD;
          else                bit_d   = bit_q + 4'd1;
        end
      end
      S_CS_HOLD: begin
        if (div_q == HALF_M1) begin
          div_d = '0;
          bit_d = '0;
          if (!ch_q)  state_d = S_GAP;
`ifdef DST_LDAC_EN
          else        state_d = S_LDAC;
`else
          else        state_d = S_IDLE;
`endif
        end
      end
      S_GAP: begin
        if (div_q == FULL_M1) begin
          state_d = S_CS_SETUP;
          div_d   = '0;
          bit_d   = '0;
          ch_d    = 1'b1;
        end
      end
`ifdef DST_LDAC_EN
      S_LDAC: begin
        if (div_q == FULL_M1) begin
          state_d = S_IDLE;
          div_d   = '0;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        div_d   = '0;
      end
    endcase
  end

  // Pin outputs are decoded from the next state so every pin leaves a flop.
  always_comb begin
    word_d = {ch_d, CFG_BUF, CFG_GA_N, 1'b1, (ch_d ? samp_b_d : samp_a_d)};
    cs_n_d = 1'b1;
    sck_d  = 1'b0;
    mosi_d = 1'b0;
    busy_d = (state_d != S_IDLE);

    case (state_d)
      S_CS_SETUP: begin
        cs_n_d = 1'b0;
        mosi_d = word_d[15];
      end
      S_SHIFT: begin
        cs_n_d = 1'b0;
        sck_d  = (div_d > HALF_M1);
        mosi_d = word_d[4'd15 - bit_d];
      end
      S_CS_HOLD: begin
        cs_n_d = 1'b0;
        mosi_d = mosi_q;
      end
      default: ;
    endcase

`ifdef DST_LDAC_EN
    ldac_n_d = (state_d != S_LDAC);
    done_d   = (state_d == S_LDAC) && (div_d == FULL_M1);
`else
    ldac_n_d = 1'b0;
    done_d   = (state_d == S_CS_HOLD) && ch_d && (div_d == HALF_M1);
`endif
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      ch_q     <= 1'b0;
      samp_a_q <= '0;
      samp_b_q <= '0;
      cs_n_q   <= 1'b1;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      ldac_n_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      ch_q     <= ch_d;
      samp_a_q <= samp_a_d;
      samp_b_q <= samp_b_d;
      cs_n_q   <= cs_n_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
      ldac_n_q <= ldac_n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
    end
  end

  assign dst_cs_n_o   = cs_n_q;
  assign dst_sck_o    = sck_q;
  assign dst_mosi_o   = mosi_q;
  assign dst_ldac_n_o = ldac_n_q;
  assign dst_busy_o   = busy_q;
  assign dst_done_o   = done_q;
  assign dst_ovr_o    = ovr_q;

endmodule

// File: tb/tb_dac_serial_tx.sv
// Directed bench for dac_serial_tx: dut0 at CLK_DIV=4, dut1 at CLK_DIV=1.
// A passive monitor decodes SPI frames and CS low time from both pins sets.
module tb_dac_serial_tx;

`ifdef DST_LDAC_EN
  localparam bit LDAC = 1'b1;
`else
  localparam bit LDAC = 1'b0;
`endif

  logic        clk;
  logic [1:0]  rst, en, start, clr;
  logic [11:0] a [2];
  logic [11:0] b [2];
  wire  [1:0]  cs_n, sck, mosi, ldac_n, busy, done, ovr;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] frm   [2][64];
  int          cslen [2][64];
  int          nbits [2][64];
  int          nfrm  [2];
  int          unstable [2];

  dac_serial_tx #(.CLK_DIV(4)) u_dut0 (
    .sys_clk_i(clk), .sys_rst_i(rst[0]), .dst_en_i(en[0]), .dst_start_i(start[0]),
    .dst_ch_a_i(a[0]), .dst_ch_b_i(b[0]), .dst_ovr_clr_i(clr[0]),
    .dst_cs_n_o(cs_n[0]), .dst_sck_o(sck[0]), .dst_mosi_o(mosi[0]), .dst_ldac_n_o(ldac_n[0]),
    .dst_busy_o(busy[0]), .dst_done_o(done[0]), .dst_ovr_o(ovr[0]));

  dac_serial_tx #(.CLK_DIV(1)) u_dut1 (
    .sys_clk_i(clk), .sys_rst_i(rst[1]), .dst_en_i(en[1]), .dst_start_i(start[1]),
    .dst_ch_a_i(a[1]), .dst_ch_b_i(b[1]), .dst_ovr_clr_i(clr[1]),
    .dst_cs_n_o(cs_n[1]), .dst_sck_o(sck[1]), .dst_mosi_o(mosi[1]), .dst_ldac_n_o(ldac_n[1]),
    .dst_busy_o(busy[1]), .dst_done_o(done[1]), .dst_ovr_o(ovr[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic int outs(input int d);
    return int'({cs_n[d], sck[d], mosi[d], ldac_n[d], busy[d], done[d], ovr[d]});
  endfunction

  // Frame decoder: shift MOSI on each SCK rise while CS is low.
  initial begin
    logic [1:0]  pcs, psck, pmosi;
    logic [15:0] sh [2];
    int          nb [2], low [2];
    pcs = 2'b11; psck = 2'b00; pmosi = 2'b00;
    for (int g = 0; g < 2; g++) begin
      sh[g] = '0; nb[g] = 0; low[g] = 0; nfrm[g] = 0; unstable[g] = 0;
    end
    forever begin
      @(posedge clk); #2;
      for (int g = 0; g < 2; g++) begin
        if (pcs[g] && !cs_n[g]) begin sh[g] = '0; nb[g] = 0; low[g] = 0; end
        if (!cs_n[g]) low[g]++;
        if (!psck[g] && sck[g]) begin
          if (mosi[g] != pmosi[g]) unstable[g]++;
          sh[g] = {sh[g][14:0], mosi[g]};
          nb[g]++;
        end
        if (!pcs[g] && cs_n[g] && nfrm[g] < 64) begin
          frm[g][nfrm[g]]   = sh[g];
          cslen[g][nfrm[g]] = low[g];
          nbits[g][nfrm[g]] = nb[g];
          nfrm[g]++;
        end
        pcs[g] = cs_n[g]; psck[g] = sck[g]; pmosi[g] = mosi[g];
      end
    end
  end

  task automatic run_xfer(input int d, input int div, input logic [11:0] av, input logic [11:0] bv,
                          input logic [15:0] ea, input logic [15:0] eb);
    int base, n, dn, lo, exp_busy;
    exp_busy = (LDAC ? 72 : 70) * div;
    base = nfrm[d];
    en[d] = 1'b1; a[d] = av; b[d] = bv; start[d] = 1'b1;
    step();
    start[d] = 1'b0;
    n = 0; dn = 0; lo = 0;
    while (busy[d] && n < 400) begin
      n++;
      if (done[d]) dn = n;
      if (!ldac_n[d]) lo++;
      step();
    end
    step(); step();
    chk("busy_len", n, exp_busy);
    chk("done_pos", dn, exp_busy);
    chk("ldac_low", lo, LDAC ? 2 * div : exp_busy);
    chk("frame_cnt", nfrm[d] - base, 2);
    if (nfrm[d] - base >= 2) begin
      chk("frame_a", int'(frm[d][base]), int'(ea));
      chk("frame_b", int'(frm[d][base+1]), int'(eb));
      chk("bits_a", nbits[d][base], 16);
      chk("cs_low_a", cslen[d][base], 34 * div);
      chk("cs_low_b", cslen[d][base+1], 34 * div);
    end
  endtask

  initial begin
    int base, n;
    rst = 2'b11; en = 2'b00; start = 2'b00; clr = 2'b00;
    a[0] = '0; a[1] = '0; b[0] = '0; b[1] = '0;
    step(); step(); step();
    chk("rst_outs0", outs(0), 7'h48);
    chk("rst_outs1", outs(1), 7'h48);
    rst = 2'b00;
    step();

    // Basic transfer at CLK_DIV=4.
    run_xfer(0, 4, 12'hABC, 12'h123, 16'h3ABC, 16'hB123);

    // Overrun while busy, clear, and clear-vs-set collision.
    base = nfrm[0];
    en[0] = 1'b1; a[0] = 12'hABC; b[0] = 12'h123; start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    repeat (49) step();
    a[0] = 12'h555; b[0] = 12'h555; start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    chk("ovr_set", ovr[0], 1);
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    chk("ovr_clr", ovr[0], 0);
    clr[0] = 1'b1; start[0] = 1'b1;
    step();
    clr[0] = 1'b0; start[0] = 1'b0;
    chk("ovr_set_wins", ovr[0], 1);
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    n = 0;
    while (!done[0] && n < 400) begin step(); n++; end
    chk("done_seen", done[0], 1);
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    chk("done_start_ovr", ovr[0], 1);
    chk("done_start_busy", busy[0], 0);
    step();
    chk("done_start_drop", busy[0], 0);
    step();
    chk("latched_a", int'(frm[0][base]), 16'h3ABC);
    chk("latched_b", int'(frm[0][base+1]), 16'hB123);

    // Start with enable low is ignored.
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0; en[0] = 1'b0; start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    chk("dis_busy", busy[0], 0);
    chk("dis_cs_n", cs_n[0], 1);
    chk("dis_ovr", ovr[0], 0);
    step();
    chk("dis_busy2", busy[0], 0);

    // Reset in SHIFT bit 7 of frame A (cycles 61..68 after acceptance).
    en[0] = 1'b1; a[0] = 12'hABC; b[0] = 12'h123; start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    repeat (29) step();
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    chk("pre_rst_ovr", ovr[0], 1);
    repeat (33) step();
    chk("pre_rst_busy", busy[0], 1);
    chk("pre_rst_cs_n", cs_n[0], 0);
    rst[0] = 1'b1;
    step();
    chk("mid_rst_outs", outs(0), 7'h48);
    rst[0] = 1'b0;
    step();
    chk("post_rst_busy", busy[0], 0);
    run_xfer(0, 4, 12'h5A5, 12'hA5A, 16'h35A5, 16'hBA5A);

    // CLK_DIV=1 boundary data.
    run_xfer(1, 1, 12'hFFF, 12'h000, 16'h3FFF, 16'hB000);

    chk("mosi_stable0", unstable[0], 0);
    chk("mosi_stable1", unstable[1], 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
